serial_div3_detector: RTL and testbench
=======================================

Name: serial_div3_detector

Overview:
Sequential front-end for the 4-bit divisible-by-3 logic. Consumes a serial bit stream, MSB first, under a valid/ready handshake. Tracks the running remainder modulo 3 with a 3-state FSM and assembles the parallel word. When a frame completes, it presents the word, the divisibility flag and the remainder to the downstream stage under a second valid/ready handshake.

Parameters:
WIDTH, 4, bits per frame; legal range 2..16.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  reset; asynchronous, active-high.
valid_i  input  1  input beat valid.
start_i  input  1  qualifies the beat as the first (MSB) bit of a frame.
bit_i  input  1  serial data bit, MSB first.
ready_o  output  1  block accepts an input beat this cycle.
out_valid_o  output  1  result valid.
out_ready_i  input  1  downstream accepts the result.
word_o  output  WIDTH  assembled frame word.
div_o  output  1  1 when word_o mod 3 == 0.
rem_o  output  2  word_o mod 3, values 0..2.

Behaviour:
- Beat accepted when valid_i & ready_o.
- Remainder step, with rem' = (2*rem + bit) mod 3:
  - rem 0: bit 0 -> 0, bit 1 -> 1
  - rem 1: bit 0 -> 2, bit 1 -> 0
  - rem 2: bit 0 -> 1, bit 1 -> 2
  - Encoding 2'b11 is never reached. If forced, treat it as 0.
- Word update on each accepted beat: word <= {word[WIDTH-2:0], bit_i}. Bit counter cnt is ceil(log2(WIDTH+1)) bits wide.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o = 1.
  - Accepted beat with start_i = 1: word = {0..0, bit_i}, rem = step(0, bit_i), cnt = 1, go to SHIFT.
  - Accepted beat with start_i = 0: discarded; no state change.
- SHIFT:
  - ready_o = 1.
  - Accepted beat with start_i = 0: rem, word and cnt all advance.
  - Accepted beat with start_i = 1: frame restart, identical to the IDLE start case; previous partial data lost.
  - When the accepted beat makes cnt == WIDTH, go to DONE.
- DONE:
  - ready_o = 0; input beats are ignored.
  - out_valid_o = 1. word_o, div_o and rem_o are registered and held stable until the handshake.
  - out_valid_o & out_ready_i: go to IDLE. ready_o = 1 on the following cycle.
- Latency: out_valid_o asserts the cycle after the WIDTH-th bit is accepted. Minimum frame period is WIDTH+1 cycles with out_ready_i held high.
- Gaps in valid_i within a frame are legal; the frame simply stalls.
- Outputs are registered. ready_o decodes directly from the state register.
- Reset (asynchronous, any state including mid-frame or DONE): state = IDLE, word = 0, rem = 0, cnt = 0, out_valid_o = 0, word_o = 0, div_o = 0, rem_o = 0. ready_o = 1 while in IDLE after reset. Any partial frame or pending result is discarded.
- div_o and rem_o are meaningful only while out_valid_o = 1.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2
  - remainder constants REM0 / REM1 / REM2
- Sub-module div3_rem_step: combinational, inputs rem_i[1:0] and bit_i, output rem_o[1:0]. Implements the table above. Reusable for other serial modulo checkers.

Test Plan:
- Reset, then send 1,0,0,1 with start_i on the first beat and out_ready_i = 1 -> 1 cycle after the last beat: out_valid_o = 1, word_o = 4'd9, div_o = 1, rem_o = 0; ready_o = 1 again 1 cycle after the handshake.
- Frame 0,1,1,1 -> word_o = 7, div_o = 0, rem_o = 1. Frame 1,1,1,0 -> word_o = 14, rem_o = 2.
- Backpressure: complete frame 12, hold out_ready_i = 0 for 5 cycles while driving valid_i beats -> ready_o = 0 throughout; outputs stay 12 / 1 / 0; no beats absorbed. Raise out_ready_i -> out_valid_o drops the next cycle.
- Restart: send 1,1, then a beat with start_i = 1 carrying 0, then 1,1,0 -> result word_o = 6, div_o = 1. Also a stray beat in IDLE without start_i is ignored.
- Asynchronous rst_i pulse mid-frame (after 2 bits) and again in DONE -> outputs zero immediately without waiting for a clock edge; the next full frame 0,0,1,1 -> word_o = 3, div_o = 1.
- Exhaustive: all 16 frames with random valid_i gaps and random out_ready_i stalls -> div_o == (i%3 == 0) and rem_o == i%3 for every i; word_o also fed to the combinational 4-bit divisible-by-3 block and compared; each check prints Pass/Fail.

Source files
------------

// File: rtl/serial_div3_detector_pkg.sv
// Shared definitions for the serial divisible-by-3 detector:
// the FSM state encoding and the remainder encodings.
package serial_div3_detector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

    // Counter width able to hold the values 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_div3_detector_rem_step.sv
// One MSB-first step of a running modulo-3 remainder: rem' = (2*rem + bit) mod 3.
// The unused encoding 2'b11 is treated as remainder 0.
module div3_rem_step
    import serial_div3_detector_pkg::*;
(
    input  logic [1:0] rem_i,
    input  logic       bit_i,
    output logic [1:0] rem_o
);

    always_comb begin
        rem_o = REM0;
        case (rem_i)
            REM0:    rem_o = bit_i ? REM1 : REM0;
            REM1:    rem_o = bit_i ? REM0 : REM2;
            REM2:    rem_o = bit_i ? REM2 : REM1;
            default: rem_o = bit_i ? REM1 : REM0;
        endcase
    end

endmodule

// File: rtl/serial_div3_detector.sv
// Serial MSB-first frame receiver that tracks the word modulo 3 and hands the
// finished word, divisibility flag and remainder downstream over valid/ready.
module serial_div3_detector
    import serial_div3_detector_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             start_i,
    input  logic             bit_i,
    output logic             ready_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] word_o,
    output logic             div_o,
    output logic [1:0]       rem_o
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [1:0]       rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             div_q, div_d;

    logic             accept;
    logic [1:0]       rem_base;
    logic [1:0]       rem_next;
    logic [CW-1:0]    cnt_inc;

    // A start beat always restarts the remainder from zero, even mid-frame.
    assign rem_base = start_i ? REM0 : rem_q;

    div3_rem_step u_rem_step (
        .rem_i (rem_base),
        .bit_i (bit_i),
        .rem_o (rem_next)
    );

    assign ready_o = (state_q != DONE);
    assign accept  = valid_i & ready_o;
    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        div_d       = div_q;

        case (state_q)
            IDLE: begin
                if (accept && start_i) begin
                    word_d  = {{(WIDTH-1){1'b0}}, bit_i};
                    rem_d   = rem_next;
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (accept) begin
                    if (start_i) begin
                        word_d = {{(WIDTH-1){1'b0}}, bit_i};
                        rem_d  = rem_next;
                        cnt_d  = CNT_ONE;
                    end else begin
                        word_d = {word_q[WIDTH-2:0], bit_i};
                        rem_d  = rem_next;
                        cnt_d  = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d     = DONE;
                            out_valid_d = 1'b1;
                            div_d       = (rem_next == REM0);
                        end
                    end
                end
            end

            DONE: begin
                // Word and remainder registers double as the held result.
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            word_q      <= '0;
            rem_q       <= REM0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            div_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            div_q       <= div_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign word_o      = word_q;
    assign div_o       = div_q;
    assign rem_o       = rem_q;

endmodule

// File: tb/tb_serial_div3_detector.sv
// Directed and randomized bench for serial_div3_detector; expected results come
// from plain integer arithmetic on the transmitted frame value.
module tb_serial_div3_detector;

    localparam int W = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         start_i;
    logic         bit_i;
    logic         ready_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] word_o;
    logic         div_o;
    logic [1:0]   rem_o;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_div3_detector #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .start_i     (start_i),
        .bit_i       (bit_i),
        .ready_o     (ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .word_o      (word_o),
        .div_o       (div_o),
        .rem_o       (rem_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one beat and hold it until the block accepts it (bounded wait).
    task automatic send_beat(input logic s, input logic b);
        int n;
        n = 0;
        valid_i = 1'b1;
        start_i = s;
        bit_i   = b;
        while (ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("beat_ready", {31'd0, ready_o}, 32'd1);
        tick();
        valid_i = 1'b0;
        start_i = 1'b0;
        bit_i   = 1'b0;
    endtask

    task automatic send_frame(input int value, input int max_gap);
        for (int i = W - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, max_gap)) tick();
            send_beat(i == W - 1, value[i]);
        end
    endtask

    // Called right after the last beat's accepting edge: result must be up now.
    task automatic finish_frame(input string name, input int value, input int stall);
        int exp_rem;
        exp_rem = value % 3;
        check({name, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        check({name, "_word"}, 32'(word_o), 32'(value));
        check({name, "_div"}, {31'd0, div_o}, (exp_rem == 0) ? 32'd1 : 32'd0);
        check({name, "_rem"}, 32'(rem_o), 32'(exp_rem));
        out_ready_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check({name, "_hold_valid"}, {31'd0, out_valid_o}, 32'd1);
            check({name, "_hold_word"}, 32'(word_o), 32'(value));
            check({name, "_hold_ready"}, {31'd0, ready_o}, 32'd0);
        end
        out_ready_i = 1'b1;
        tick();
        check({name, "_drop_valid"}, {31'd0, out_valid_o}, 32'd0);
        check({name, "_ready_back"}, {31'd0, ready_o}, 32'd1);
        out_ready_i = 1'b0;
        $display("[TB] frame %s value=%0d word=%0d rem=%0d", name, value, value, exp_rem);
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, {31'd0, out_valid_o}, 32'd0);
        check({name, "_word"}, 32'(word_o), 32'd0);
        check({name, "_div"}, {31'd0, div_o}, 32'd0);
        check({name, "_rem"}, 32'(rem_o), 32'd0);
        check({name, "_ready"}, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        start_i     = 1'b0;
        bit_i       = 1'b0;
        out_ready_i = 1'b0;

        // Reset state.
        repeat (3) tick();
        check_zero("reset");
        rst_i = 1'b0;
        tick();

        // Frame 9 back-to-back with downstream always ready.
        out_ready_i = 1'b1;
        send_frame(9, 0);
        finish_frame("nine", 9, 0);

        send_frame(7, 0);
        finish_frame("seven", 7, 0);
        send_frame(14, 1);
        finish_frame("fourteen", 14, 1);

        // Backpressure: beats offered while the result waits must be ignored.
        send_frame(12, 0);
        for (int s = 0; s < 5; s++) begin
            valid_i = 1'b1;
            start_i = 1'($urandom_range(0, 1));
            bit_i   = 1'($urandom_range(0, 1));
            tick();
            check("bp_ready", {31'd0, ready_o}, 32'd0);
            check("bp_valid", {31'd0, out_valid_o}, 32'd1);
            check("bp_word", 32'(word_o), 32'd12);
            check("bp_div", {31'd0, div_o}, 32'd1);
            check("bp_rem", 32'(rem_o), 32'd0);
        end
        valid_i = 1'b0;
        start_i = 1'b0;
        finish_frame("twelve", 12, 0);

        // Restart: a start beat mid-frame discards the partial data.
        send_beat(1'b1, 1'b1);
        send_beat(1'b0, 1'b1);
        send_beat(1'b1, 1'b0);
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b1);
        send_beat(1'b0, 1'b0);
        finish_frame("restart6", 6, 1);

        // Stray beat in IDLE without start is dropped.
        send_beat(1'b0, 1'b1);
        check("stray_valid", {31'd0, out_valid_o}, 32'd0);
        send_frame(9, 0);
        finish_frame("after_stray", 9, 0);

        // Asynchronous reset mid-frame: takes effect without a clock edge.
        send_beat(1'b1, 1'b1);
        send_beat(1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1 check_zero("arst_mid");
        #1 rst_i = 1'b0;
        tick();

        // Asynchronous reset while a result is pending.
        send_frame(5, 0);
        check("pre_arst_valid", {31'd0, out_valid_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1 check_zero("arst_done");
        #1 rst_i = 1'b0;
        tick();
        send_frame(3, 0);
        finish_frame("three", 3, 0);

        // All frames with random input gaps and downstream stalls.
        for (int v = 0; v < (1 << W); v++) begin
            send_frame(v, 2);
            finish_frame($sformatf("exh%0d", v), v, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
